// File: rtl/mem_access.sv
// Memory-access stage between the XM and MW latches: issues one data-memory
// request per lw/sw, stalls upstream until ack or timeout, then forwards results.
module mem_access #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ir_in,
  input  logic [31:0] o_in,
  input  logic [31:0] b_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [11:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic [31:0] ir_out,
  output logic [31:0] o_out,
  output logic [31:0] d_out,
  output logic        err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [4:0] OP_SW = 5'b00111;
  localparam logic [4:0] OP_LW = 5'b01000;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t      r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic        r_req, w_req_nxt;
  logic        r_we;
  logic [11:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_ir_cap, r_o_cap;
  logic [31:0] r_ir, r_o, r_d;
  logic [31:0] w_ir_nxt, w_o_nxt, w_d_nxt;
  logic        r_err, w_err_nxt;
  logic        w_capture;
  logic        w_stall;
  logic        w_in_is_mem;
  logic        w_cap_is_lw;

  assign w_in_is_mem = (ir_in[31:27] == OP_SW) || (ir_in[31:27] == OP_LW);
  assign w_cap_is_lw = (r_ir_cap[31:27] == OP_LW);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_req_nxt   = r_req;
    w_err_nxt   = r_err;
    w_capture   = 1'b0;
    w_stall     = 1'b0;
    w_ir_nxt    = '0;
    w_o_nxt     = '0;
    w_d_nxt     = '0;
    case (r_state)
      S_IDLE: begin
        if (w_in_is_mem) begin
          w_stall     = 1'b1;
          w_capture   = 1'b1;
          w_req_nxt   = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_WAIT;
        end else begin
          w_ir_nxt = ir_in;
          w_o_nxt  = o_in;
        end
      end
      S_WAIT: begin
        if (mem_ack) begin
          w_ir_nxt    = r_ir_cap;
          w_o_nxt     = r_o_cap;
          w_d_nxt     = w_cap_is_lw ? mem_rdata : 32'd0;
          w_req_nxt   = 1'b0;
          w_state_nxt = S_IDLE;
        end else if (r_cnt == CNT_LAST) begin
          // Timeout completes like an ack returning zero, and latches err.
          w_ir_nxt    = r_ir_cap;
          w_o_nxt     = r_o_cap;
          w_err_nxt   = 1'b1;
          w_req_nxt   = 1'b0;
          w_state_nxt = S_IDLE;
        end else begin
          w_stall   = 1'b1;
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_req    <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_ir_cap <= '0;
      r_o_cap  <= '0;
      r_ir     <= '0;
      r_o      <= '0;
      r_d      <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_req   <= w_req_nxt;
      r_err   <= w_err_nxt;
      r_ir    <= w_ir_nxt;
      r_o     <= w_o_nxt;
      r_d     <= w_d_nxt;
      // Request fields are loaded only at issue so they stay stable during WAIT.
      if (w_capture) begin
        r_we     <= (ir_in[31:27] == OP_SW);
        r_addr   <= o_in[11:0];
        r_wdata  <= b_in;
        r_ir_cap <= ir_in;
        r_o_cap  <= o_in;
      end
    end
  end

  assign stall     = w_stall & ~reset;
  assign mem_req   = r_req;
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign ir_out    = r_ir;
  assign o_out     = r_o;
  assign d_out     = r_d;
  assign err       = r_err;

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum WAIT cycles before a memory access is forcibly completed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately when high.
REQ-004 ir_in  input  32  instruction from XM latch ir_out.
REQ-005 o_in  input  32  ALU result from XM latch o_out; memory address source.
REQ-006 b_in  input  32  rt/rd data from XM latch b_out; store data source.
REQ-007 mem_req  output  1  registered request to data memory, held high for the whole access.
REQ-008 mem_we  output  1  registered; 1 = store, 0 = load; valid while mem_req=1.
REQ-009 mem_addr  output  12  registered word address, o_in[11:0] captured at request.
REQ-010 mem_wdata  output  32  registered store data, b_in captured at request.
REQ-011 mem_ack  input  1  memory completion, sampled only while mem_req=1.
REQ-012 mem_rdata  input  32  load data, valid in the same cycle as mem_ack.
REQ-013 stall  output  1  combinational; 1 = hold XM latch and all upstream stages (drives their en low).
REQ-014 ir_out, o_out, d_out  output  32 each  registered MW-side instruction, ALU result, load data.
REQ-015 err  output  1  sticky timeout flag.

Function
REQ-016 Opcode is ir_in[31:27]; sw = 5'b00111, lw = 5'b01000; every other opcode is a non-memory op.
REQ-017 FSM states: IDLE, WAIT.
REQ-018 IDLE with non-memory op: stall=0; at edge ir_out<=ir_in, o_out<=o_in, d_out<=0; stay IDLE.
REQ-019 IDLE with lw/sw: stall=1; at edge mem_req<=1, mem_we<=(sw), mem_addr<=o_in[11:0], mem_wdata<=b_in, capture ir_in/o_in internally, counter<=0, go WAIT; ir_out/o_out/d_out <= 0 (nop bubble).
REQ-020 WAIT with mem_ack=0 and counter<TIMEOUT-1: stall=1; counter increments; outputs load nop (all zero).
REQ-021 WAIT with mem_ack=1: stall=0; at edge ir_out/o_out <= captured values, d_out <= mem_rdata for lw, 0 for sw; mem_req<=0; go IDLE.
REQ-022 WAIT with mem_ack=0 and counter==TIMEOUT-1: treated as completion with rdata=0; stall=0; err<=1; mem_req<=0; go IDLE.
REQ-023 Minimum memory op latency: 2 cycles (1 stall cycle); ack k cycles after mem_req rises gives k+1 stall cycles.
REQ-024 mem_ack while in IDLE (mem_req=0) is ignored; no state or output change.
REQ-025 mem_addr, mem_we, mem_wdata hold stable for the full duration of mem_req=1.
REQ-026 Back-to-back memory ops: the op loaded on the completing edge is seen in IDLE next cycle and starts a new access; mem_req drops for at least one cycle between accesses.
REQ-027 err, once set, remains 1 until reset; further timeouts do not alter it.

Reset
REQ-028 On reset: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, counter=0, ir_out=o_out=d_out=0, err=0.
REQ-029 Reset asserted mid-access (WAIT) abandons the access immediately; mem_req falls asynchronously; no completion is delivered.
REQ-030 While reset is high, stall is 0.

Verification
REQ-031 add (ir_in=0x0000_0000 opcode 0), o_in=0x5 -> stall=0, next edge ir_out=ir_in, o_out=0x5, d_out=0.
REQ-032 lw, o_in=0x123, mem_ack returned 2 cycles after mem_req rises with rdata=0xDEADBEEF -> stall high 3 cycles, mem_addr=0x123, mem_we=0, then d_out=0xDEADBEEF, o_out=0x123, mem_req=0.
REQ-033 sw, o_in=0x7FF, b_in=0xA5A5A5A5, ack in first WAIT cycle -> mem_we=1, mem_wdata=0xA5A5A5A5, stall 1 cycle, d_out=0.
REQ-034 lw with no ack, TIMEOUT=16 -> 16 WAIT cycles, then completion with d_out=0, err=1 and held until reset.
REQ-035 Reset pulse during WAIT cycle 3 -> mem_req=0 immediately, all outputs 0, state IDLE; a later ack is ignored.
REQ-036 Two consecutive lw ops -> two distinct mem_req pulses separated by at least one low cycle, both results delivered in order with correct ir_out.
